// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 16-bit adder is reused LSW first with a registered carry.
// Optional zero-result flag output is enabled by defining ADDER_SEQ_ZERO_FLAG_EN.

module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module adder_seq_ctrl #(
  parameter int WORDS = 4,
  parameter int W     = 16 * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow,
`ifdef ADDER_SEQ_ZERO_FLAG_EN
  output logic         zero,
`endif
  output logic [1:0]   dbg_state
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Handshake: start is accepted only in IDLE; busy is high for the WORDS
  // RUN cycles; done pulses for one cycle, after which result/cout/overflow
  // stay stable until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_sub;
  logic [15:0]     r_a_w   [WORDS];
  logic [15:0]     r_b_w   [WORDS];
  logic [15:0]     r_res_w [WORDS];
  logic            r_cout;
  logic            r_ovf;

  logic            w_last;
  logic [15:0]     w_add_a;
  logic [15:0]     w_add_b;
  logic            w_add_cin;
  logic [15:0]     w_add_s;
  logic            w_add_cout;

  assign w_last    = (r_idx == IW'(WORDS - 1));
  assign w_add_a   = r_a_w[r_idx];
  assign w_add_b   = r_b_w[r_idx] ^ {16{r_sub}};
  assign w_add_cin = (r_idx == '0) ? r_sub : r_carry;

  adder_16bit u_add (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .s    (w_add_s),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_a_w[i]   <= '0;
        r_b_w[i]   <= '0;
        r_res_w[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            r_sub <= op_sub;
            for (int i = 0; i < WORDS; i++) begin
              r_a_w[i] <= a_in[16*i +: 16];
              r_b_w[i] <= b_in[16*i +: 16];
            end
          end
        end
        S_RUN: begin
          r_res_w[r_idx] <= w_add_s;
          r_carry        <= w_add_cout;
          if (w_last) begin
            r_cout <= w_add_cout;
            // Signed overflow judged on the effective (possibly inverted) B MSW.
            r_ovf  <= (w_add_a[15] == w_add_b[15]) && (w_add_s[15] != w_add_a[15]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_SEQ_ZERO_FLAG_EN
  logic r_zacc;
  logic r_zero;
  logic w_zacc_in;

  // Running AND of per-word zero tests; word 0 restarts the accumulation.
  assign w_zacc_in = ((r_idx == '0) ? 1'b1 : r_zacc) & (w_add_s == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zacc <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_zacc <= w_zacc_in;
      if (w_last) r_zero <= w_zacc_in;
    end
  end

  assign zero = r_zero;
`endif

  for (genvar g = 0; g < WORDS; g++) begin : g_res
    assign result[16*g +: 16] = r_res_w[g];
  end

  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (WORDS=4): latency, results, flags, ignored starts, reset abort.
// Zero flag is also checked when ADDER_SEQ_ZERO_FLAG_EN is defined.

module tb_adder_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [1:0]   dbg_state;
`ifdef ADDER_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  adder_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
`ifdef ADDER_SEQ_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start at the next edge, check busy window and done cycle, then results.
  task automatic run_op(input string tag, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_cout, input logic exp_ovf);
    op_sub = sub;
    a_in   = a;
    b_in   = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    a_in   = {$urandom(), $urandom()};
    b_in   = {$urandom(), $urandom()};
    op_sub = ~sub;
    for (int i = 0; i < WORDS; i++) begin
      check({tag, "_busy"}, W'(busy), W'(1));
      check({tag, "_nodone"}, W'(done), W'(0));
      tick();
    end
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_busy_lo"}, W'(busy), W'(0));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_cout"}, W'(cout), W'(exp_cout));
    check({tag, "_ovf"}, W'(overflow), W'(exp_ovf));
`ifdef ADDER_SEQ_ZERO_FLAG_EN
    check({tag, "_zero"}, W'(zero), W'(exp_res == '0));
`endif
    tick();
    check({tag, "_done_pulse"}, W'(done), W'(0));
    check({tag, "_idle"}, W'(dbg_state), W'(0));
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int n_done;
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a_in   = '0;
    b_in   = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, W'(0));
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(overflow), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    tick();
    check("idle_stay", W'(dbg_state), W'(0));

    run_op("t1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0);
    run_op("t2", 1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("t3a", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("t3b", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("t4", 1'b0, 64'h0000_0001_0001_0001, 64'h0000_FFFF_FFFF_FFFF,
           64'h0001_0001_0001_0000, 1'b0, 1'b0);
    run_op("neg_ovf", 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1);
    run_op("sub_eq", 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 1'b0);

    // Test 5: starts in RUN (cycle 2) and DONE (cycle 5) are ignored
    n_done = 0;
    op_sub = 1'b0;
    a_in   = 64'h1;
    b_in   = 64'h2;
    start  = 1'b1;
    tick();                       // cycle 1
    start = 1'b0;
    if (done) n_done++;
    tick();                       // cycle 2
    if (done) n_done++;
    a_in  = 64'h5;
    b_in  = 64'h5;
    start = 1'b1;
    tick();                       // cycle 3
    start = 1'b0;
    if (done) n_done++;
    tick();                       // cycle 4
    if (done) n_done++;
    tick();                       // cycle 5
    if (done) n_done++;
    check("t5_done_c5", W'(done), W'(1));
    start = 1'b1;
    tick();                       // cycle 6
    start = 1'b0;
    if (done) n_done++;
    check("t5_idle_c6", W'(dbg_state), W'(0));
    check("t5_result", result, 64'h3);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    check("t5_one_done", W'(n_done), W'(1));
    check("t5_still_idle", W'(dbg_state), W'(0));

    // Test 6: reset mid-RUN aborts with no done
    op_sub = 1'b0;
    a_in   = 64'h1111_2222_3333_4444;
    b_in   = 64'hF000_0000_0000_0000;
    start  = 1'b1;
    tick();                       // cycle 1
    start = 1'b0;
    tick();                       // cycle 2
    rst = 1'b1;
    tick();                       // cycle 3
    rst = 1'b0;
    check("t6_state", W'(dbg_state), W'(0));
    check("t6_busy", W'(busy), W'(0));
    check("t6_result", result, W'(0));
    check("t6_cout", W'(cout), W'(0));
    check("t6_ovf", W'(overflow), W'(0));
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n_done++;
      tick();
    end
    check("t6_no_done", W'(n_done), W'(0));
    run_op("t6_fresh", 1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
